// File: rtl/edge_event_arbiter_if.sv
// Edge-event arbiter bus: edge/mask inputs from the detector side, serialized
// event stream with valid/ready, plus overflow and busy status.
interface edge_event_arbiter_if #(
  parameter int WIDTH = 4
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] pos_edge;
  logic [WIDTH-1:0] neg_edge;
  logic [WIDTH-1:0] pos_mask;
  logic [WIDTH-1:0] neg_mask;
  logic             evt_valid;
  logic             evt_ready;
  logic [CW-1:0]    evt_chan;
  logic             evt_pol;
  logic [WIDTH-1:0] ovf;
  logic             ovf_clr;
  logic             busy;

  modport master (
    input  pos_edge, neg_edge, pos_mask, neg_mask, evt_ready, ovf_clr,
    output evt_valid, evt_chan, evt_pol, ovf, busy
  );

  modport slave (
    output pos_edge, neg_edge, pos_mask, neg_mask, evt_ready, ovf_clr,
    input  evt_valid, evt_chan, evt_pol, ovf, busy
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Captures masked per-channel edge pulses as pending slots and serializes them
// round-robin onto a single valid/ready event stream with sticky overflow.
module edge_event_arbiter_lane (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_pos_ev,
  input  logic       i_neg_ev,
  input  logic [1:0] i_gnt,
  input  logic       i_ovf_clr,
  output logic [1:0] o_pend,
  output logic       o_ovf
);
  logic [1:0] r_pend;
  logic       r_ovf;
  logic [1:0] w_ev;
  logic       w_drop;

  // bit 0 = rising slot, bit 1 = falling slot; a grant frees the slot so a
  // same-cycle event on it is retained rather than counted as overflow
  assign w_ev   = {i_neg_ev, i_pos_ev};
  assign w_drop = |(w_ev & r_pend & ~i_gnt);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~i_gnt) | w_ev;
      r_ovf  <= (r_ovf & ~i_ovf_clr) | w_drop;
    end
  end

  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
endmodule

module edge_event_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  edge_event_arbiter_if.master  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NS = 2 * WIDTH;
  localparam int PW = $clog2(NS);

  logic [NS-1:0]    w_pend;
  logic [NS-1:0]    w_gnt;
  logic [WIDTH-1:0] w_ovf;
  logic [WIDTH-1:0] w_pos_ev;
  logic [WIDTH-1:0] w_neg_ev;
  logic [PW-1:0]    r_ptr;
  logic             r_valid;
  logic [CW-1:0]    r_chan;
  logic             r_pol;
  logic             w_found;
  logic [PW-1:0]    w_slot;
  logic [PW:0]      w_idx;
  logic             w_load;
  logic             w_grant;

  assign w_pos_ev = bus.pos_edge & bus.pos_mask;
  assign w_neg_ev = bus.neg_edge & bus.neg_mask;

  for (genvar c = 0; c < WIDTH; c++) begin : g_lane
    edge_event_arbiter_lane u_lane (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_pos_ev  (w_pos_ev[c]),
      .i_neg_ev  (w_neg_ev[c]),
      .i_gnt     (w_gnt[2*c +: 2]),
      .i_ovf_clr (bus.ovf_clr),
      .o_pend    (w_pend[2*c +: 2]),
      .o_ovf     (w_ovf[c])
    );
  end

  // first set slot at or above ptr, wrapping modulo NS
  always_comb begin
    w_found = 1'b0;
    w_slot  = '0;
    w_idx   = '0;
    for (int i = 0; i < NS; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(NS)) w_idx = w_idx - (PW+1)'(NS);
      if (!w_found && w_pend[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_slot  = w_idx[PW-1:0];
      end
    end
  end

  assign w_load  = !r_valid || bus.evt_ready;
  assign w_grant = w_load && w_found;
  assign w_gnt   = w_grant ? (NS'(1) << w_slot) : '0;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_pol   <= 1'b0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_chan  <= CW'(w_slot >> 1);
      r_pol   <= ~w_slot[0];
      r_ptr   <= (w_slot == PW'(NS-1)) ? '0 : w_slot + PW'(1);
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.evt_valid = r_valid;
  assign bus.evt_chan  = r_chan;
  assign bus.evt_pol   = r_pol;
  assign bus.ovf       = w_ovf;
  assign bus.busy      = (|w_pend) || r_valid;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected {chan,pol} pushed with the
// stimulus, popped and compared on each accepted event.
module tb_edge_event_arbiter;
  logic clk = 1'b0;
  logic n_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  edge_event_arbiter_if #(.WIDTH(4)) bus ();
  edge_event_arbiter #(.WIDTH(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && bus.evt_valid && bus.evt_ready) begin
      if (sb.size() == 0) chk("spurious_evt", 32'(bus.evt_valid), 32'd0);
      else chk("evt", 32'({bus.evt_chan, bus.evt_pol}), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [3:0] p, input logic [3:0] n);
    bus.pos_edge = p; bus.neg_edge = n;
    tick();
    bus.pos_edge = '0; bus.neg_edge = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (bus.busy && k < 60) begin tick(); k++; end
    chk("drain_busy", 32'(bus.busy), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd0);
    chk({tag, "_ovf"},   32'(bus.ovf),       32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_chan"},  32'(bus.evt_chan),  32'd0);
    chk({tag, "_pol"},   32'(bus.evt_pol),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    bus.pos_edge = '0; bus.neg_edge = '0;
    bus.pos_mask = 4'hF; bus.neg_mask = 4'hF;
    bus.evt_ready = 1'b1; bus.ovf_clr = 1'b0;

    // 1: reset with random edges, then idle
    repeat (2) begin
      @(posedge clk); #1;
      bus.pos_edge = 4'($urandom); bus.neg_edge = 4'($urandom);
    end
    tick();
    bus.pos_edge = '0; bus.neg_edge = '0;
    chk_idle("rst");
    n_rst = 1'b1;
    repeat (3) tick();
    chk_idle("post_rst");

    // 2: single event, 2-cycle latency, one-cycle valid
    sb.push_back({2'd2, 1'b1});
    pulse(4'b0100, 4'b0000);
    chk("lat_valid_n", 32'(bus.evt_valid), 32'd0);
    chk("lat_busy_n",  32'(bus.busy),      32'd1);
    tick();
    chk("single_valid", 32'(bus.evt_valid), 32'd1);
    tick();
    chk("single_drop", 32'(bus.evt_valid), 32'd0);
    chk("single_busy", 32'(bus.busy),      32'd0);
    chk("single_sb",   32'(sb.size()),     32'd0);

    // 3: round robin from ptr 0
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    sb.push_back({2'd0, 1'b1}); sb.push_back({2'd1, 1'b1}); sb.push_back({2'd3, 1'b1});
    pulse(4'b1011, 4'b0000);
    drain();
    sb.push_back({2'd0, 1'b1}); sb.push_back({2'd0, 1'b0}); sb.push_back({2'd3, 1'b1});
    pulse(4'b1001, 4'b0001);
    drain();

    // 4: backpressure and overflow
    bus.evt_ready = 1'b0;
    sb.push_back({2'd1, 1'b1}); sb.push_back({2'd1, 1'b1});
    pulse(4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 32'(bus.evt_valid), 32'd1);
      chk("hold_evt",   32'({bus.evt_chan, bus.evt_pol}), 32'({2'd1, 1'b1}));
    end
    pulse(4'b0010, 4'b0000);
    chk("bp_ovf0", 32'(bus.ovf), 32'd0);
    repeat (2) tick();
    pulse(4'b0010, 4'b0000);
    chk("bp_ovf1",  32'(bus.ovf), 32'h2);
    chk("bp_valid", 32'(bus.evt_valid), 32'd1);
    bus.evt_ready = 1'b1;
    drain();
    chk("bp_ovf_sticky", 32'(bus.ovf), 32'h2);

    // 5: masking and ovf_clr
    bus.neg_mask = 4'b1011;
    pulse(4'b0000, 4'b0100);
    chk("mask_busy", 32'(bus.busy), 32'd0);
    chk("mask_ovf",  32'(bus.ovf),  32'h2);
    tick();
    chk("mask_valid", 32'(bus.evt_valid), 32'd0);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    bus.evt_ready = 1'b0;
    sb.push_back({2'd3, 1'b1}); sb.push_back({2'd3, 1'b1});
    pulse(4'b1000, 4'b0000);
    tick();
    pulse(4'b1000, 4'b0000);
    chk("clr_pre_ovf", 32'(bus.ovf), 32'd0);
    bus.ovf_clr = 1'b1;
    pulse(4'b1000, 4'b0000);
    bus.ovf_clr = 1'b0;
    chk("clr_race_ovf", 32'(bus.ovf), 32'h8);
    bus.evt_ready = 1'b1;
    drain();
    bus.neg_mask = 4'hF;

    // 6: reset mid-operation
    bus.evt_ready = 1'b0;
    pulse(4'b1111, 4'b0000);
    tick();
    chk("mid_valid", 32'(bus.evt_valid), 32'd1);
    chk("mid_busy",  32'(bus.busy),      32'd1);
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    chk_idle("mid_rst");
    bus.evt_ready = 1'b1;
    repeat (4) tick();
    chk("mid_quiet", 32'(bus.evt_valid), 32'd0);
    sb.push_back({2'd0, 1'b1}); sb.push_back({2'd3, 1'b1});
    pulse(4'b1001, 4'b0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Scheduler placed behind a WIDTH-channel edge detector. It captures the per-channel pos_edge/neg_edge pulses as pending events.
- Pending events are arbitrated round-robin into a single serialized event stream with a valid/ready handshake.
- Lets one downstream consumer service all channels without losing single-cycle pulses.
- Per-channel sticky overflow flags record events that were coalesced or dropped while a previous event of the same kind was still pending.

Parameters:
- WIDTH, 4, number of edge-detector channels (>=1).
- CW, $clog2(WIDTH) but minimum 1, width of channel index output (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  synchronous active-low reset.
- pos_edge  input  WIDTH  rising-edge pulses from edge detector, one bit per channel.
- neg_edge  input  WIDTH  falling-edge pulses from edge detector.
- pos_mask  input  WIDTH  1 = capture rising edges on that channel.
- neg_mask  input  WIDTH  1 = capture falling edges on that channel.
- evt_valid  output  1  output event present.
- evt_ready  input  1  consumer accepts event when evt_valid & evt_ready.
- evt_chan  output  CW  channel index of presented event.
- evt_pol  output  1  1 = rising, 0 = falling.
- ovf  output  WIDTH  sticky per-channel overflow.
- ovf_clr  input  1  clears all ovf bits.
- busy  output  1  combinational: any pending bit set or evt_valid.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - Clears pending[2*WIDTH], ovf, evt_valid, evt_chan, evt_pol and the rr pointer (all to 0).
  - Reset mid-operation discards all pending and presented events.
- Slots:
  - slot 2c = channel c rising; slot 2c+1 = channel c falling; 2*WIDTH slots total.
  - Round-robin pointer ptr has width $clog2(2*WIDTH).
- Capture:
  - A set event bit is pos_edge[c]&pos_mask[c] (slot 2c) or neg_edge[c]&neg_mask[c] (slot 2c+1).
  - A set event bit sets pending[slot] at the next clk edge.
  - Masked edges are ignored entirely, with no pending and no overflow.
  - A mask change does not clear existing pending bits.
- Arbitration (combinational from registered pending):
  - Search starts at ptr, ascends, and wraps modulo 2*WIDTH.
  - The first set slot wins.
  - A grant occurs only when the output stage can load, i.e. evt_valid==0 or (evt_valid & evt_ready).
- Output stage (single register):
  - On grant: evt_valid<=1, evt_chan<=slot>>1, evt_pol<=~slot[0], pending[slot] cleared, ptr<=(slot+1) mod 2*WIDTH.
  - On accept with no grant: evt_valid<=1'b0, and chan/pol hold their last values.
  - With evt_valid=1 and evt_ready=0, the outputs hold stable.
  - One event transfers per cycle at most; back-to-back transfers are supported at full rate.
- Latency:
  - An edge sampled at clk edge N sets pending at N. evt_valid is high after edge N+1 if the stage is free.
  - Minimum latency is 2 cycles from pulse to presented event.
- Coalescing/overflow:
  - If an event arrives on a slot whose pending bit is set and that slot is not granted in the same cycle, it is dropped and ovf[c] is set.
  - If an event arrives on the slot being granted in the same cycle, pending stays set (new event retained) and there is no overflow.
  - A rising and a falling event on the same channel in the same cycle are both captured (separate slots).
- ovf_clr:
  - Clears all ovf bits.
  - A same-cycle new overflow on channel c wins, so ovf[c]=1.
- busy = |pending | evt_valid.

Test Plan:
1. Reset: drive n_rst=0 for 2 cycles with random edges -> evt_valid=0, ovf=0, busy=0, evt_chan=0, evt_pol=0; after release with no edges, all outputs remain 0.
2. Single event (WIDTH=4, masks all 1, evt_ready=1): pos_edge=4'b0100 for 1 cycle at edge N -> evt_valid=1 for exactly one cycle after N+1 with evt_chan=2, evt_pol=1; busy then drops to 0.
3. Round-robin (evt_ready=1): first burst pos_edge=4'b1011 for 1 cycle -> events ch0,ch1,ch3 rising on consecutive cycles. Second burst pos_edge=4'b1001 plus neg_edge=4'b0001 -> order ch0 rise, ch0 fall, ch3 rise.
4. Backpressure/overflow (evt_ready=0):
   - pos_edge[1] pulse at cycle 0 -> evt_valid=1, chan=1, pol=1, held.
   - pos_edge[1] at cycle 5 -> pending set, ovf=0.
   - pos_edge[1] at cycle 8 -> ovf=4'b0010.
   - Set evt_ready=1 -> exactly two ch1 rising events, then evt_valid=0; ovf stays 4'b0010.
5. Masking and clear:
   - neg_mask=4'b1011; neg_edge[2] pulse -> no event, no ovf.
   - ovf_clr pulse -> ovf=0.
   - ovf_clr asserted in the same cycle as a new ch3 overflow -> ovf=4'b1000.
6. Reset mid-operation: 3 pending events with evt_valid=1 and evt_ready=0; n_rst=0 for 1 cycle -> all cleared. With evt_ready=1 afterwards, no events emerge; the next edge is served from ptr=0 order.
